// File: rtl/osc_switch_pkg.sv
// Shared types and defaults for the oscillator switch controller.
//   - osc_state_e : switch sequencer states
//   - *_DEF       : default parameter values for the meter and sequencer
//   - sat_inc     : saturating increment for the 16-bit edge counter
package osc_switch_pkg;

  localparam int unsigned WINDOW_DEF     = 4096;
  localparam int unsigned CNT_MIN_DEF    = 190;
  localparam int unsigned CNT_MAX_DEF    = 220;
  localparam int unsigned OK_WINDOWS_DEF = 4;
  localparam int unsigned HOLD_CYC_DEF   = 64;

  localparam int unsigned CNT_W = 16;

  localparam logic TGT_RC  = 1'b0;
  localparam logic TGT_XTL = 1'b1;

  typedef enum logic [2:0] {
    RC_RUN,
    HOLD_PRE,
    SWITCH,
    HOLD_POST,
    XTL_RUN
  } osc_state_e;

  // Increment by one when inc is set, holding at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != '1)) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

endpackage

// File: rtl/osc_freq_meter.sv
// Crystal frequency meter: synchronizes the divided crystal toggle, counts
// both edges over fixed CLK windows and qualifies the crystal after a run of
// consecutive in-range windows.
//   clk_i, rst_i : fabric clock, async active-high reset
//   tog_i        : asynchronous divided-crystal toggle
//   xtl_ok_o     : crystal qualified
//   meas_cnt_o   : edge count of the last completed window
module osc_freq_meter
  import osc_switch_pkg::*;
#(
  parameter int unsigned WINDOW     = WINDOW_DEF,
  parameter int unsigned CNT_MIN    = CNT_MIN_DEF,
  parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
  parameter int unsigned OK_WINDOWS = OK_WINDOWS_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tog_i,
  output logic             xtl_ok_o,
  output logic [CNT_W-1:0] meas_cnt_o
);

  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned OK_W  = $clog2(OK_WINDOWS + 1);

  logic             sync1_q, sync2_q, tog_prev_q;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
  logic [OK_W-1:0]  ok_cnt_q, ok_cnt_d;
  logic             xtl_ok_q, xtl_ok_d;
  logic             edge_c, win_end_c, in_range_c;

  assign edge_c     = sync2_q ^ tog_prev_q;
  assign win_end_c  = (win_cnt_q == WIN_W'(WINDOW - 1));
  assign in_range_c = (edge_cnt_q >= CNT_W'(CNT_MIN)) && (edge_cnt_q <= CNT_W'(CNT_MAX));

  // Window bookkeeping; an edge seen in the closing cycle seeds the next window.
  always_comb begin
    win_cnt_d  = win_cnt_q + WIN_W'(1);
    edge_cnt_d = sat_inc(edge_cnt_q, edge_c);
    meas_cnt_d = meas_cnt_q;
    ok_cnt_d   = ok_cnt_q;
    xtl_ok_d   = xtl_ok_q;
    if (win_end_c) begin
      win_cnt_d  = '0;
      edge_cnt_d = CNT_W'(edge_c);
      meas_cnt_d = edge_cnt_q;
      if (in_range_c) begin
        if (ok_cnt_q < OK_W'(OK_WINDOWS)) begin
          ok_cnt_d = ok_cnt_q + OK_W'(1);
        end
        if (ok_cnt_q >= OK_W'(OK_WINDOWS - 1)) begin
          xtl_ok_d = 1'b1;
        end
      end else begin
        ok_cnt_d = '0;
        xtl_ok_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      tog_prev_q <= 1'b0;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      meas_cnt_q <= '0;
      ok_cnt_q   <= '0;
      xtl_ok_q   <= 1'b0;
    end else begin
      sync1_q    <= tog_i;
      sync2_q    <= sync1_q;
      tog_prev_q <= sync2_q;
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      meas_cnt_q <= meas_cnt_d;
      ok_cnt_q   <= ok_cnt_d;
      xtl_ok_q   <= xtl_ok_d;
    end
  end

  assign xtl_ok_o   = xtl_ok_q;
  assign meas_cnt_o = meas_cnt_q;

endmodule

// File: rtl/osc_switch_ctrl.sv
// RC/crystal clock source switch controller. Qualifies the crystal with
// osc_freq_meter and sequences glitch-safe source changes with the
// downstream CCC held in reset around the mux select change.
//   CLK, RESET   : fabric clock, async active-high reset
//   XTL_DIV_TOG  : asynchronous divided-crystal toggle
//   SEL_XTL_REQ  : 1 = run from crystal, 0 = run from RC
//   FAULT_CLR    : single-cycle clear of FAULT
//   CLK_SEL      : mux select, 0 = RC, 1 = XTL
//   CCC_HOLD     : CCC/PLL hold during a source change
//   XTL_OK       : crystal frequency qualified
//   SWITCH_BUSY  : switch sequence in progress
//   FAULT        : sticky automatic-fallback flag
//   MEAS_CNT     : edge count of the last completed window
module osc_switch_ctrl
  import osc_switch_pkg::*;
#(
  parameter int unsigned WINDOW     = WINDOW_DEF,
  parameter int unsigned CNT_MIN    = CNT_MIN_DEF,
  parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
  parameter int unsigned OK_WINDOWS = OK_WINDOWS_DEF,
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             XTL_DIV_TOG,
  input  logic             SEL_XTL_REQ,
  input  logic             FAULT_CLR,
  output logic             CLK_SEL,
  output logic             CCC_HOLD,
  output logic             XTL_OK,
  output logic             SWITCH_BUSY,
  output logic             FAULT,
  output logic [CNT_W-1:0] MEAS_CNT
);

  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  osc_state_e        state_q, state_d;
  logic              target_q, target_d;
  logic              clk_sel_q, clk_sel_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_last_c, fault_set_c;

  osc_freq_meter #(
    .WINDOW     (WINDOW),
    .CNT_MIN    (CNT_MIN),
    .CNT_MAX    (CNT_MAX),
    .OK_WINDOWS (OK_WINDOWS)
  ) u_meter (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .tog_i      (XTL_DIV_TOG),
    .xtl_ok_o   (XTL_OK),
    .meas_cnt_o (MEAS_CNT)
  );

  assign hold_last_c = (hold_cnt_q == HOLD_W'(HOLD_CYC - 1));

  // Sequencer next state; the request is only looked at in the RUN states.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    clk_sel_d   = clk_sel_q;
    hold_cnt_d  = hold_cnt_q;
    fault_set_c = 1'b0;
    unique case (state_q)
      RC_RUN: begin
        if (SEL_XTL_REQ && XTL_OK) begin
          state_d    = HOLD_PRE;
          target_d   = TGT_XTL;
          hold_cnt_d = '0;
        end
      end
      XTL_RUN: begin
        if (!SEL_XTL_REQ || !XTL_OK) begin
          state_d     = HOLD_PRE;
          target_d    = TGT_RC;
          hold_cnt_d  = '0;
          fault_set_c = !XTL_OK;
        end
      end
      HOLD_PRE: begin
        // Crystal lost before the mux moved: skip SWITCH, stay on RC.
        if ((target_q == TGT_XTL) && !XTL_OK) begin
          state_d    = HOLD_POST;
          target_d   = TGT_RC;
          hold_cnt_d = '0;
        end else if (hold_last_c) begin
          state_d    = SWITCH;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      SWITCH: begin
        clk_sel_d  = target_q;
        state_d    = HOLD_POST;
        hold_cnt_d = '0;
      end
      HOLD_POST: begin
        if (hold_last_c) begin
          state_d    = clk_sel_q ? XTL_RUN : RC_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d    = HOLD_POST;
        target_d   = TGT_RC;
        hold_cnt_d = '0;
      end
    endcase
    busy_d  = (state_d != RC_RUN) && (state_d != XTL_RUN);
    // A new fault outranks a coincident clear.
    fault_d = fault_set_c | (fault_q & ~FAULT_CLR);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= HOLD_POST;
      target_q   <= TGT_RC;
      clk_sel_q  <= 1'b0;
      busy_q     <= 1'b1;
      fault_q    <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      clk_sel_q  <= clk_sel_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign CLK_SEL     = clk_sel_q;
  assign CCC_HOLD    = busy_q;
  assign SWITCH_BUSY = busy_q;
  assign FAULT       = fault_q;

endmodule

// File: tb/tb_osc_switch_ctrl.sv
// Directed bench for osc_switch_ctrl with default parameters.
// Clock period 20 units (50 MHz); crystal toggle half-period 400 units
// (20 MHz / 8) or 267 units (~30 MHz / 8). cyc counts CLK rising edges since
// the last RESET release and is read at falling edges.
module tb_osc_switch_ctrl;

  logic        CLK;
  logic        RESET;
  logic        XTL_DIV_TOG;
  logic        SEL_XTL_REQ;
  logic        FAULT_CLR;
  logic        CLK_SEL;
  logic        CCC_HOLD;
  logic        XTL_OK;
  logic        SWITCH_BUSY;
  logic        FAULT;
  logic [15:0] MEAS_CNT;

  int vectors;
  int miscompares;
  int cyc;
  int tog_half;
  logic tog_en;

  osc_switch_ctrl dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .XTL_DIV_TOG (XTL_DIV_TOG),
    .SEL_XTL_REQ (SEL_XTL_REQ),
    .FAULT_CLR   (FAULT_CLR),
    .CLK_SEL     (CLK_SEL),
    .CCC_HOLD    (CCC_HOLD),
    .XTL_OK      (XTL_OK),
    .SWITCH_BUSY (SWITCH_BUSY),
    .FAULT       (FAULT),
    .MEAS_CNT    (MEAS_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  // Crystal divider model, phase-offset from CLK.
  initial begin
    XTL_DIV_TOG = 1'b0;
    #3;
    forever begin
      #(tog_half);
      if (tog_en) XTL_DIV_TOG = ~XTL_DIV_TOG;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    vectors++;
    assert ((obs >= 32'(lo)) && (obs <= 32'(hi))) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d..%0d (cyc %0d)", tag, obs, lo, hi, cyc);
    end
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clk_sel"}, 32'(CLK_SEL), 32'd0);
    chk({tag, "_ccc_hold"}, 32'(CCC_HOLD), 32'd1);
    chk({tag, "_busy"}, 32'(SWITCH_BUSY), 32'd1);
    chk({tag, "_xtl_ok"}, 32'(XTL_OK), 32'd0);
    chk({tag, "_fault"}, 32'(FAULT), 32'd0);
    chk({tag, "_meas"}, 32'(MEAS_CNT), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    tog_half    = 400;
    tog_en      = 1'b0;
    RESET       = 1'b1;
    SEL_XTL_REQ = 1'b0;
    FAULT_CLR   = 1'b0;

    // Reset values.
    @(negedge CLK);
    chk_reset_vals("rst");
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    cyc   = 0;

    // 20 MHz crystal with request held: qualification then RC -> XTL.
    tog_en      = 1'b1;
    SEL_XTL_REQ = 1'b1;
    goto(63);    chk("post_rst_hold63", 32'(CCC_HOLD), 32'd1);
    goto(64);    chk("post_rst_hold64", 32'(CCC_HOLD), 32'd0);
                 chk("post_rst_busy64", 32'(SWITCH_BUSY), 32'd0);
    goto(4095);  chk("w1_meas_pre", 32'(MEAS_CNT), 32'd0);
    goto(4096);  chk_rng("w1_meas", 32'(MEAS_CNT), 200, 208);
                 chk("w1_xtl_ok", 32'(XTL_OK), 32'd0);
    goto(16383); chk("w4_xtl_ok_pre", 32'(XTL_OK), 32'd0);
    goto(16384); chk("w4_xtl_ok", 32'(XTL_OK), 32'd1);
                 chk("w4_hold", 32'(CCC_HOLD), 32'd0);
    goto(16385); chk("pre_hold_on", 32'(CCC_HOLD), 32'd1);
    goto(16449); chk("pre_clk_sel", 32'(CLK_SEL), 32'd0);
    goto(16450); chk("sw_clk_sel", 32'(CLK_SEL), 32'd1);
                 chk("sw_hold", 32'(CCC_HOLD), 32'd1);
    goto(16513); chk("post_hold_last", 32'(CCC_HOLD), 32'd1);
    goto(16514); chk("xtl_run_hold", 32'(CCC_HOLD), 32'd0);
                 chk("xtl_run_busy", 32'(SWITCH_BUSY), 32'd0);
                 chk("xtl_run_fault", 32'(FAULT), 32'd0);

    // Crystal stops at a window boundary: fallback with FAULT, set beats clear.
    goto(20470); tog_en = 1'b0;
    goto(20480); chk_rng("w5_meas", 32'(MEAS_CNT), 200, 208);
                 chk("w5_xtl_ok", 32'(XTL_OK), 32'd1);
    goto(24575); chk("w6_xtl_ok_pre", 32'(XTL_OK), 32'd1);
    goto(24576); chk("w6_meas_zero", 32'(MEAS_CNT), 32'd0);
                 chk("w6_xtl_ok", 32'(XTL_OK), 32'd0);
                 chk("w6_hold", 32'(CCC_HOLD), 32'd0);
                 chk("w6_fault", 32'(FAULT), 32'd0);
    FAULT_CLR = 1'b1;
    goto(24577); chk("fault_set_wins", 32'(FAULT), 32'd1);
                 chk("fb_hold_on", 32'(CCC_HOLD), 32'd1);
    goto(24578); chk("fault_cleared", 32'(FAULT), 32'd0);
    FAULT_CLR = 1'b0;
    goto(24641); chk("fb_clk_sel_pre", 32'(CLK_SEL), 32'd1);
    goto(24642); chk("fb_clk_sel", 32'(CLK_SEL), 32'd0);
    goto(24705); chk("fb_hold_last", 32'(CCC_HOLD), 32'd1);
    goto(24706); chk("fb_hold_off", 32'(CCC_HOLD), 32'd0);

    // 30 MHz crystal: out of range, never qualified.
    tog_half = 267;
    tog_en   = 1'b1;
    goto(32768); chk_rng("w8_meas_fast", 32'(MEAS_CNT), 300, 312);
                 chk("w8_xtl_ok", 32'(XTL_OK), 32'd0);
                 chk("w8_clk_sel", 32'(CLK_SEL), 32'd0);
                 chk("w8_hold", 32'(CCC_HOLD), 32'd0);
                 chk("w8_fault", 32'(FAULT), 32'd0);

    // Back to 20 MHz without request; then abort during HOLD_PRE.
    tog_half    = 400;
    SEL_XTL_REQ = 1'b0;
    goto(36864); chk_rng("w9_meas", 32'(MEAS_CNT), 200, 208);
                 chk("w9_xtl_ok", 32'(XTL_OK), 32'd0);
    goto(49140); tog_en = 1'b0;
    goto(49151); chk("w12_xtl_ok_pre", 32'(XTL_OK), 32'd0);
    goto(49152); chk("w12_xtl_ok", 32'(XTL_OK), 32'd1);
    goto(49160); chk("noreq_hold", 32'(CCC_HOLD), 32'd0);
    goto(53220); SEL_XTL_REQ = 1'b1;
                 chk("ab_hold_pre", 32'(CCC_HOLD), 32'd0);
    goto(53221); chk("ab_hold_on", 32'(CCC_HOLD), 32'd1);
    goto(53248); chk("ab_xtl_ok", 32'(XTL_OK), 32'd0);
                 chk("ab_meas", 32'(MEAS_CNT), 32'd0);
    goto(53290); chk("ab_clk_sel", 32'(CLK_SEL), 32'd0);
                 chk("ab_busy", 32'(SWITCH_BUSY), 32'd1);
    goto(53312); chk("ab_hold_last", 32'(CCC_HOLD), 32'd1);
    goto(53313); chk("ab_hold_off", 32'(CCC_HOLD), 32'd0);
                 chk("ab_clk_sel_end", 32'(CLK_SEL), 32'd0);
                 chk("ab_fault", 32'(FAULT), 32'd0);

    // Requalify and switch again, then reset during HOLD_POST.
    tog_en = 1'b1;
    goto(69631); chk("w17_xtl_ok_pre", 32'(XTL_OK), 32'd0);
    goto(69632); chk("w17_xtl_ok", 32'(XTL_OK), 32'd1);
    goto(69697); chk("r_clk_sel_pre", 32'(CLK_SEL), 32'd0);
    goto(69698); chk("r_clk_sel", 32'(CLK_SEL), 32'd1);
    goto(69700);
    #5 RESET = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    cyc   = 0;
    goto(63);    chk("r_hold63", 32'(CCC_HOLD), 32'd1);
    goto(64);    chk("r_hold64", 32'(CCC_HOLD), 32'd0);
                 chk("r_clk_sel64", 32'(CLK_SEL), 32'd0);
                 chk("r_xtl_ok64", 32'(XTL_OK), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
